hex_scan_display: RTL

Parametrised N-digit multiplexed hex display driver, the next generation of our fixed 8-digit scanner. It generates its own scan timing from the system clock with a clock enable, so no divided clocks are needed. It adds a load-strobed shadow register, leading-zero blanking, per-digit blinking, 16-level brightness PWM and a frame pulse. It sits between any data source and the board's 7-segment pins; the top level applies pin polarity inversion.

---
 rtl/hex_scan_display.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hex_scan_display.sv
// N-digit multiplexed hex display driver: self-timed digit scan, load-strobed
// shadow registers, leading-zero blanking, per-digit blink, 16-level PWM, frame pulse.
module hex_scan_display #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 4096,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data,
  input  logic                load,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic                lz_blank,
  input  logic [3:0]          bright,
  output logic [DIGITS-1:0]   anodes,
  output logic [6:0]          segments,
  output logic                frame
);

  localparam int STEP  = SCAN_DIV / 16;
  localparam int SUB_W = $clog2(STEP);
  localparam int DIG_W = $clog2(DIGITS);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // The slot prescaler is kept as {phase, sub} with pre = phase*STEP + sub, so the
  // PWM phase falls out directly even when STEP is not a power of two.
  logic [SUB_W-1:0]    sub;
  logic [3:0]          phase;
  logic [DIG_W-1:0]    dig;
  logic [FC_W-1:0]     frame_cnt;
  logic                blink_ph;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_mask;

  logic                slot_end;
  logic                frame_end;
  logic [DIGITS:0]     tail_zero;
  logic [3:0]          nibble;
  logic                blank;
  logic [DIGITS-1:0]   onehot;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'h7E;
      4'h1:    return 7'h30;
      4'h2:    return 7'h6D;
      4'h3:    return 7'h79;
      4'h4:    return 7'h33;
      4'h5:    return 7'h5B;
      4'h6:    return 7'h5F;
      4'h7:    return 7'h70;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h7B;
      4'hA:    return 7'h77;
      4'hB:    return 7'h1F;
      4'hC:    return 7'h4E;
      4'hD:    return 7'h3D;
      4'hE:    return 7'h4F;
      default: return 7'h47;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    slot_end  = (phase == 4'd15) && (sub == SUB_W'(STEP - 1));
    frame_end = slot_end && (dig == DIG_W'(DIGITS - 1));

    // tail_zero[i] is set when nibbles i..DIGITS-1 of the shadow value are all zero.
    tail_zero         = '0;
    tail_zero[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tail_zero[i] = tail_zero[i+1] && (sh_data[4*i +: 4] == 4'h0);
    end

    nibble      = sh_data[{dig, 2'b00} +: 4];
    blank       = (lz_blank && (dig != '0) && tail_zero[dig]) || (blink_ph && sh_mask[dig]);
    onehot      = '0;
    onehot[dig] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow registers are reset as well, so no stale value is shown after rst.
      sub       <= '0;
      phase     <= '0;
      dig       <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
      sh_data   <= '0;
      sh_mask   <= '0;
      anodes    <= '0;
      segments  <= '0;
      frame     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: outputs below see the pre-edge counters and shadow.
      anodes   <= (!blank && (phase < bright)) ? onehot : '0;
      segments <= blank ? 7'h00 : hex_to_seg(nibble);
      frame    <= frame_end;

      if (load) begin
        sh_data <= data;
        sh_mask <= blink_mask;
      end

      if (sub == SUB_W'(STEP - 1)) begin
        sub   <= '0;
        phase <= phase + 4'd1;
      end else begin
        sub <= sub + 1'b1;
      end

      if (slot_end) begin
        dig <= (dig == DIG_W'(DIGITS - 1)) ? '0 : dig + 1'b1;
      end

      if (frame_end) begin
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule
